// File: rtl/div_iter_pkg.sv
// div_iter_pkg: shared state encodings and sizing constants for the iterative divider
package div_iter_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = DIV_WIDTH;
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;
endpackage

// File: rtl/div_iter_sign_fix.sv
// div_sign_fix: operand magnitudes on entry and signed correction of quotient/remainder on exit
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic             signed_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] rem,
    input  logic             neg_q,
    input  logic             neg_r,
    output logic             a_neg,
    output logic             b_neg,
    output logic [WIDTH-1:0] abs_a,
    output logic [WIDTH-1:0] abs_b,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);
    // Two's complement negation wraps 0x8000_0000 onto itself, which gives the required overflow result
    always_comb begin
        a_neg  = signed_op & src_a[WIDTH-1];
        b_neg  = signed_op & src_b[WIDTH-1];
        abs_a  = a_neg ? -src_a : src_a;
        abs_b  = b_neg ? -src_b : src_b;
        res_lo = neg_q ? -quo : quo;
        res_hi = neg_r ? -rem : rem;
    end
endmodule

// File: rtl/div_iter.sv
// div_iter: radix-2 restoring DIV/DIVU unit with pipeline stall; DIV_ZERO_FAST_EN short-circuits zero divisors
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             E_div_start,
    input  logic             E_div_signed,
    input  logic [WIDTH-1:0] E_src_a,
    input  logic [WIDTH-1:0] E_src_b,
    input  logic             M_except,
    output logic             E_div_stall,
    output logic             div_done,
    output logic [WIDTH-1:0] div_hi,
    output logic [WIDTH-1:0] div_lo
);
    localparam int CW = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic             neg_q_q, neg_q_d, neg_r_q, neg_r_d, done_q, done_d;
    logic [WIDTH:0]   rem_sh, diff;
    logic             step_ok;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b, res_lo, res_hi;

    div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .signed_op (E_div_signed),
        .src_a     (E_src_a),
        .src_b     (E_src_b),
        .quo       (quo_step),
        .rem       (rem_step),
        .neg_q     (neg_q_q),
        .neg_r     (neg_r_q),
        .a_neg     (a_neg),
        .b_neg     (b_neg),
        .abs_a     (abs_a),
        .abs_b     (abs_b),
        .res_lo    (res_lo),
        .res_hi    (res_hi)
    );

    assign E_div_stall = E_div_start & ~M_except & (state_q != DIV_DONE);
    assign div_done    = done_q;
    assign div_hi      = hi_q;
    assign div_lo      = lo_q;

    // One restoring step: shift the next dividend bit in, keep the subtraction only if it did not borrow
    always_comb begin
        rem_sh   = {rem_q, quo_q[WIDTH-1]};
        diff     = rem_sh - {1'b0, b_q};
        step_ok  = ~diff[WIDTH];
        rem_step = step_ok ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], step_ok};
    end

    // Next-state and datapath selection; a zero divisor naturally yields all-ones quotient and |a| remainder
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        b_d     = b_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        if (M_except) begin
            state_d = DIV_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (E_div_start) begin
                        quo_d   = abs_a;
                        b_d     = abs_b;
                        rem_d   = '0;
                        cnt_d   = '0;
                        neg_q_d = a_neg ^ b_neg;
                        neg_r_d = a_neg;
`ifdef DIV_ZERO_FAST_EN
                        if (E_src_b == '0) begin
                            state_d = DIV_DONE;
                            done_d  = 1'b1;
                            hi_d    = E_src_a;
                            lo_d    = a_neg ? {{(WIDTH-1){1'b0}}, 1'b1} : '1;
                        end else begin
                            state_d = DIV_BUSY;
                        end
`else
                        state_d = DIV_BUSY;
`endif
                    end
                end
                DIV_BUSY: begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = DIV_DONE;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        hi_d    = res_hi;
                        lo_d    = res_lo;
                    end
                end
                DIV_DONE: state_d = DIV_IDLE;
                default:  state_d = DIV_IDLE;
            endcase
        end
    end

    // State register; reset overrides every other condition
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            b_q     <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            b_q     <= b_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed self-checking bench for div_iter
module tb_div_iter;
    import div_iter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        E_div_start = 1'b0;
    logic        E_div_signed = 1'b0;
    logic [31:0] E_src_a = '0;
    logic [31:0] E_src_b = '0;
    logic        M_except = 1'b0;
    logic        E_div_stall, div_done;
    logic [31:0] div_hi, div_lo;

    int passed = 0;
    int total = 0;

    div_iter #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .E_div_start  (E_div_start),
        .E_div_signed (E_div_signed),
        .E_src_a      (E_src_a),
        .E_src_b      (E_src_b),
        .M_except     (M_except),
        .E_div_stall  (E_div_stall),
        .div_done     (div_done),
        .div_hi       (div_hi),
        .div_lo       (div_lo)
    );

    always #5 clk = ~clk;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZERO_STALLS = 1;
`else
    localparam int ZERO_STALLS = 33;
`endif

    // Issue one divide and follow it to its done cycle; operands are scrambled after the first cycle
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output logic [31:0] hi, output logic [31:0] lo,
                          output logic seen, output logic stall_at_done);
        @(negedge clk);
        E_div_start = 1'b1;
        E_div_signed = sgn;
        E_src_a = a;
        E_src_b = b;
        stalls = 0;
        seen = 1'b0;
        hi = '0;
        lo = '0;
        stall_at_done = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            #1;
            if (div_done) begin
                seen = 1'b1;
                hi = div_hi;
                lo = div_lo;
                stall_at_done = E_div_stall;
            end else begin
                if (E_div_stall) stalls++;
                @(negedge clk);
                E_src_a = $urandom;
                E_src_b = $urandom;
            end
        end
    endtask

    task automatic end_op();
        @(negedge clk);
        E_div_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (div_done !== 1'b0) $display("FAIL reset_done got %b expected 0", div_done); else passed++;
        total++; if (div_hi !== 32'h0 || div_lo !== 32'h0) $display("FAIL reset_hilo got %h/%h expected 0/0", div_hi, div_lo); else passed++;
        total++; if (E_div_stall !== 1'b0) $display("FAIL reset_stall got %b expected 0", E_div_stall); else passed++;
        total++; if (dut.state_q !== DIV_IDLE) $display("FAIL reset_state got %0d expected IDLE", dut.state_q); else passed++;
    endtask

    task automatic test_divu_basic();
        int st; logic [31:0] hi, lo; logic seen, sd;
        do_div(1'b0, 32'd100, 32'd7, st, hi, lo, seen, sd);
        total++; if (!seen) $display("FAIL divu100_7_done got no pulse expected pulse"); else passed++;
        total++; if (st !== 33) $display("FAIL divu100_7_stall got %0d expected 33", st); else passed++;
        total++; if (sd !== 1'b0) $display("FAIL divu100_7_stall_on_done got %b expected 0", sd); else passed++;
        total++; if (lo !== 32'd14 || hi !== 32'd2) $display("FAIL divu100_7 got lo=%h hi=%h expected lo=e hi=2", lo, hi); else passed++;
        end_op();
        #1;
        total++; if (div_done !== 1'b0) $display("FAIL done_one_cycle got %b expected 0", div_done); else passed++;
        total++; if (div_lo !== 32'd14 || div_hi !== 32'd2) $display("FAIL hold_results got %h/%h expected e/2", div_lo, div_hi); else passed++;
    endtask

    task automatic test_signed();
        int st; logic [31:0] hi, lo; logic seen, sd;
        logic [31:0] va [6] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1000};
        logic [31:0] vb [6] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'd1001};
        logic        vs [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] el [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] eh [6] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1000};
        for (int i = 0; i < 6; i++) begin
            do_div(vs[i], va[i], vb[i], st, hi, lo, seen, sd);
            total++;
            if (!seen || lo !== el[i] || hi !== eh[i])
                $display("FAIL arith_%0d got done=%b lo=%h hi=%h expected lo=%h hi=%h", i, seen, lo, hi, el[i], eh[i]);
            else passed++;
            end_op();
        end
    endtask

    task automatic test_div_zero();
        int st; logic [31:0] hi, lo; logic seen, sd;
        do_div(1'b1, 32'hFFFF_FFFB, 32'd0, st, hi, lo, seen, sd);
        total++; if (!seen || lo !== 32'd1 || hi !== 32'hFFFF_FFFB) $display("FAIL divzero_neg got lo=%h hi=%h expected lo=1 hi=fffffffb", lo, hi); else passed++;
        total++; if (st !== ZERO_STALLS) $display("FAIL divzero_stall got %0d expected %0d", st, ZERO_STALLS); else passed++;
        end_op();
        do_div(1'b1, 32'd5, 32'd0, st, hi, lo, seen, sd);
        total++; if (!seen || lo !== 32'hFFFF_FFFF || hi !== 32'd5) $display("FAIL divzero_pos got lo=%h hi=%h expected lo=ffffffff hi=5", lo, hi); else passed++;
        end_op();
        do_div(1'b0, 32'h8000_0003, 32'd0, st, hi, lo, seen, sd);
        total++; if (!seen || lo !== 32'hFFFF_FFFF || hi !== 32'h8000_0003) $display("FAIL divzero_u got lo=%h hi=%h expected lo=ffffffff hi=80000003", lo, hi); else passed++;
        end_op();
    endtask

    task automatic test_except();
        int dones = 0;
        @(negedge clk);
        E_div_start = 1'b1; E_div_signed = 1'b0; E_src_a = 32'd50; E_src_b = 32'd3;
        repeat (11) @(negedge clk);
        M_except = 1'b1;
        #1;
        total++; if (dut.state_q !== DIV_BUSY) $display("FAIL except_in_busy got %0d expected BUSY", dut.state_q); else passed++;
        total++; if (E_div_stall !== 1'b0) $display("FAIL except_stall got %b expected 0", E_div_stall); else passed++;
        @(negedge clk);
        M_except = 1'b0; E_div_start = 1'b0;
        #1;
        total++; if (dut.state_q !== DIV_IDLE) $display("FAIL except_idle got %0d expected IDLE", dut.state_q); else passed++;
        for (int i = 0; i < 40; i++) begin
            if (div_done) dones++;
            @(negedge clk);
            #1;
        end
        total++; if (dones !== 0) $display("FAIL except_no_done got %0d pulses expected 0", dones); else passed++;
        total++; if (div_lo !== 32'hFFFF_FFFF || div_hi !== 32'h8000_0003) $display("FAIL except_hold got lo=%h hi=%h expected ffffffff/80000003", div_lo, div_hi); else passed++;
    endtask

    task automatic test_back_to_back();
        int st; logic [31:0] hi, lo; logic seen, sd;
        do_div(1'b0, 32'd9, 32'd3, st, hi, lo, seen, sd);
        total++; if (!seen || lo !== 32'd3 || hi !== 32'd0) $display("FAIL b2b_first got lo=%h hi=%h expected 3/0", lo, hi); else passed++;
        do_div(1'b0, 32'd10, 32'd4, st, hi, lo, seen, sd);
        total++; if (!seen || lo !== 32'd2 || hi !== 32'd2) $display("FAIL b2b_second got lo=%h hi=%h expected 2/2", lo, hi); else passed++;
        total++; if (st !== 33) $display("FAIL b2b_second_stall got %0d expected 33", st); else passed++;
        end_op();
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        E_div_start = 1'b1; E_div_signed = 1'b0; E_src_a = 32'd77; E_src_b = 32'd5;
        repeat (6) @(negedge clk);
        rst = 1'b1; E_div_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (div_hi !== 32'h0 || div_lo !== 32'h0 || div_done !== 1'b0) $display("FAIL rst_mid_out got hi=%h lo=%h done=%b expected 0/0/0", div_hi, div_lo, div_done); else passed++;
        total++; if (dut.state_q !== DIV_IDLE || E_div_stall !== 1'b0) $display("FAIL rst_mid_state got %0d stall=%b expected IDLE/0", dut.state_q, E_div_stall); else passed++;
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_except();
        test_back_to_back();
        test_rst_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
